display_arbiter: RTL and testbench

//  Time-shares the 4-digit seven-segment display between NREQ requesters.

---
 rtl/display_pkg.sv | 13 +
 rtl/display_arbiter_rr_picker.sv | 32 +++
 rtl/display_arbiter.sv | 96 +++++++++
 tb/tb_display_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and defaults for the seven-segment display subsystem.
package display_pkg;

  localparam int DISP_W    = 16;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_DWELL = 50000;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin pick: first unmasked request at or after start, wrapping mod NREQ.
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int OWN_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [OWN_W-1:0] start,
  output logic [OWN_W-1:0] sel,
  output logic             any
);

  logic [NREQ-1:0] eff;

  assign eff = req & ~mask;

  // Walk the ring backwards so the last hit written is the closest to start.
  always_comb begin
    int idx;
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NREQ;
      if (eff[idx]) begin
        sel = OWN_W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin time-sharing of the 4-digit display between NREQ requesters,
// each slot held for at least DWELL cycles.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DWELL   = DEF_DWELL,
  parameter int DWELL_W = 16,
  parameter int OWN_W   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [DISP_W*NREQ-1:0] data,
  output logic [DISP_W-1:0]      num,
  output logic [OWN_W-1:0]       owner,
  output logic                   owner_valid,
  output logic [NREQ-1:0]        grant
);

  state_t              state;
  logic [DWELL_W-1:0]  timer;
  logic [OWN_W-1:0]    last;
  logic [OWN_W-1:0]    pick_start;
  logic [NREQ-1:0]     pick_mask;
  logic [OWN_W-1:0]    sel;
  logic                any;
  logic                slot_end;
  logic                take;

  function automatic logic [OWN_W-1:0] rr_next(input logic [OWN_W-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // In SHOW the current owner is masked so a slot end only hands over to someone else.
  always_comb begin
    pick_mask = '0;
    if (state == SHOW) begin
      pick_start       = rr_next(owner);
      pick_mask[owner] = 1'b1;
    end else begin
      pick_start = rr_next(last);
    end
  end

  rr_picker #(
    .NREQ  (NREQ),
    .OWN_W (OWN_W)
  ) u_pick (
    .req   (req),
    .mask  (pick_mask),
    .start (pick_start),
    .sel   (sel),
    .any   (any)
  );

  assign slot_end = (state == SHOW) && (timer == '0);
  assign take     = any && ((state == IDLE) || slot_end);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      num         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      grant       <= '0;
      timer       <= '0;
      last        <= OWN_W'(NREQ - 1);
    end else begin
      grant <= '0;
      if (take) begin
        state       <= SHOW;
        num         <= data[DISP_W*int'(sel) +: DISP_W];
        owner       <= sel;
        last        <= sel;
        owner_valid <= 1'b1;
        grant       <= NREQ'(1) << sel;
        timer       <= DWELL_W'(DWELL - 1);
      end else if (state == SHOW) begin
        // Live tracking only while the owner still asks; otherwise num freezes.
        if (req[owner]) begin
          num <= data[DISP_W*int'(owner) +: DISP_W];
        end
        if (timer != '0) begin
          timer <= timer - 1'b1;
        end else if (req[owner]) begin
          timer <= DWELL_W'(DWELL - 1);
        end else begin
          state       <= IDLE;
          owner_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Scenario bench for display_arbiter (NREQ=4, DWELL=4) with a queue-based scoreboard.
module tb_display_arbiter;

  localparam int NREQ  = 4;
  localparam int DWELL = 4;

  typedef struct packed {
    logic [15:0] num;
    logic [1:0]  owner;
    logic        ov;
    logic [3:0]  grant;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] d [4];
  logic [63:0] data;
  logic [15:0] num;
  logic [1:0]  owner;
  logic        owner_valid;
  logic [3:0]  grant;

  exp_t sb [$];
  int   total;
  int   bad;

  assign data = {d[3], d[2], d[1], d[0]};

  display_arbiter #(
    .NREQ    (NREQ),
    .DWELL   (DWELL),
    .DWELL_W (16),
    .OWN_W   (2)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .req         (req),
    .data        (data),
    .num         (num),
    .owner       (owner),
    .owner_valid (owner_valid),
    .grant       (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue what must appear after the edge, then compare.
  task automatic step(input string tag, input logic r, input logic [3:0] q,
                      input logic [15:0] en, input logic [1:0] eo,
                      input logic ev, input logic [3:0] eg);
    exp_t e;
    rst = r;
    req = q;
    sb.push_back('{num: en, owner: eo, ov: ev, grant: eg});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".num"},   32'(num),         32'(e.num));
      chk({tag, ".owner"}, 32'(owner),       32'(e.owner));
      chk({tag, ".ov"},    32'(owner_valid), 32'(e.ov));
      chk({tag, ".grant"}, 32'(grant),       32'(e.grant));
    end
  endtask

  initial begin
    int o;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = '0;
    for (int i = 0; i < 4; i++) d[i] = 16'(i * 16'h1111);

    // Reset held two cycles with everyone requesting.
    step("rst0", 1'b1, 4'hF, 16'h0000, 2'd0, 1'b0, 4'h0);
    step("rst1", 1'b1, 4'hF, 16'h0000, 2'd0, 1'b0, 4'h0);

    // Round robin from requester 0, each value held exactly DWELL cycles.
    for (int s = 0; s < 9; s++) begin
      o = s % 4;
      for (int c = 0; c < DWELL; c++) begin
        step($sformatf("rr%0d_%0d", s, c), 1'b0, 4'hF, 16'(o * 16'h1111), 2'(o), 1'b1,
             (c == 0) ? 4'(1 << o) : 4'h0);
      end
    end
    step("rr9_0", 1'b0, 4'hF, 16'h1111, 2'd1, 1'b1, 4'b0010);
    step("rr9_1", 1'b0, 4'hF, 16'h1111, 2'd1, 1'b1, 4'b0000);

    // Reset mid-slot (timer=2); afterwards the pointer starts again at 0.
    step("mrst",  1'b1, 4'hF, 16'h0000, 2'd0, 1'b0, 4'h0);
    step("mrst1", 1'b0, 4'hF, 16'h0000, 2'd0, 1'b1, 4'b0001);
    step("clr",   1'b1, 4'h0, 16'h0000, 2'd0, 1'b0, 4'h0);

    // Single requester: renews silently, tracks data live.
    d[2] = 16'hABCD;
    step("one_g", 1'b0, 4'b0100, 16'hABCD, 2'd2, 1'b1, 4'b0100);
    for (int c = 0; c < 8; c++) begin
      step($sformatf("one_%0d", c), 1'b0, 4'b0100, 16'hABCD, 2'd2, 1'b1, 4'h0);
    end
    d[2] = 16'h1234;
    step("one_chg", 1'b0, 4'b0100, 16'h1234, 2'd2, 1'b1, 4'h0);
    d[2] = 16'h7777;
    step("one_d1", 1'b0, 4'b0000, 16'h1234, 2'd2, 1'b1, 4'h0);
    step("one_d2", 1'b0, 4'b0000, 16'h1234, 2'd2, 1'b1, 4'h0);
    step("one_d3", 1'b0, 4'b0000, 16'h1234, 2'd2, 1'b0, 4'h0);

    // Early drop by owner 1: num frozen for the rest of the slot, then idle.
    d[1] = 16'h5A5A;
    step("ed_g", 1'b0, 4'b0010, 16'h5A5A, 2'd1, 1'b1, 4'b0010);
    d[1] = 16'hFFFF;
    step("ed_1", 1'b0, 4'b0000, 16'h5A5A, 2'd1, 1'b1, 4'h0);
    step("ed_2", 1'b0, 4'b0000, 16'h5A5A, 2'd1, 1'b1, 4'h0);
    step("ed_3", 1'b0, 4'b0000, 16'h5A5A, 2'd1, 1'b1, 4'h0);
    step("ed_4", 1'b0, 4'b0000, 16'h5A5A, 2'd1, 1'b0, 4'h0);
    step("ed_5", 1'b0, 4'b0000, 16'h5A5A, 2'd1, 1'b0, 4'h0);

    // Late arrival of requester 3 while 0 owns: handover exactly at slot end.
    d[0] = 16'h0F0F;
    d[3] = 16'h3C3C;
    step("la_g0", 1'b0, 4'b0001, 16'h0F0F, 2'd0, 1'b1, 4'b0001);
    step("la_1",  1'b0, 4'b0001, 16'h0F0F, 2'd0, 1'b1, 4'h0);
    step("la_2",  1'b0, 4'b1001, 16'h0F0F, 2'd0, 1'b1, 4'h0);
    step("la_3",  1'b0, 4'b1001, 16'h0F0F, 2'd0, 1'b1, 4'h0);
    step("la_g3", 1'b0, 4'b1001, 16'h3C3C, 2'd3, 1'b1, 4'b1000);
    step("la_5",  1'b0, 4'b1001, 16'h3C3C, 2'd3, 1'b1, 4'h0);
    step("la_6",  1'b0, 4'b1001, 16'h3C3C, 2'd3, 1'b1, 4'h0);
    step("la_7",  1'b0, 4'b1001, 16'h3C3C, 2'd3, 1'b1, 4'h0);
    step("la_b0", 1'b0, 4'b1001, 16'h0F0F, 2'd0, 1'b1, 4'b0001);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
